// File: rtl/hamming_pkg.sv
// Shared definitions for the extended Hamming(16,11) coder/decoder pair.
package hamming_pkg;

    localparam int unsigned IL = 11;
    localparam int unsigned OL = 16;

    // Hamming positions holding parity bits (position 0 is the overall parity).
    localparam logic [3:0] ParityPos [4] = '{4'd1, 4'd2, 4'd4, 4'd8};

    // Hamming positions holding payload bits, payload MSB first.
    localparam logic [3:0] DataPos [IL] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StCorrect,
        StExtract,
        StDone
    } dec_state_e;

    // Hamming position n lives at code word bit OL-1-n.
    function automatic logic [3:0] pos_to_bit(input logic [3:0] n);
        return 4'(OL - 1) - n;
    endfunction

endpackage

// File: rtl/hamming_data_extract.sv
// Pulls the 11-bit payload out of a 16-bit code word.
module hamming_data_extract
    import hamming_pkg::*;
(
    input  logic [OL-1:0] code_i,
    output logic [IL-1:0] data_o
);

    // Gather the payload bits from their Hamming positions, MSB first.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < IL; k++) begin
            data_o[IL-1-k] = code_i[pos_to_bit(DataPos[k])];
        end
    end

endmodule

// File: rtl/hamming_decoder_rtl.sv
// Extended Hamming(16,11) SECDED decoder with a serial syndrome scan and a
// 4-phase start/ready_out handshake.
module hamming_decoder_rtl #(
    parameter int unsigned IL = 11,
    parameter int unsigned OL = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [OL-1:0] hamm_code_in,
    output logic          ready_out,
    output logic [IL-1:0] binary_out,
    output logic          err_single,
    output logic          err_double
);

    import hamming_pkg::*;

    dec_state_e    state_q, state_d;
    logic [OL-1:0] code_q, code_d;
    logic [3:0]    syn_q, syn_d;
    logic          par_q, par_d;
    logic [4:0]    pos_q, pos_d;
    logic          ready_q, ready_d;
    logic [IL-1:0] bin_q, bin_d;
    logic          es_q, es_d;
    logic          ed_q, ed_d;
    logic [IL-1:0] payload;

    hamming_data_extract u_extract (
        .code_i (code_q),
        .data_o (payload)
    );

    // Next-state and datapath updates for the decode sequence.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        syn_d   = syn_q;
        par_d   = par_q;
        pos_d   = pos_q;
        ready_d = ready_q;
        bin_d   = bin_q;
        es_d    = es_q;
        ed_d    = ed_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    code_d  = hamm_code_in;
                    syn_d   = '0;
                    par_d   = 1'b0;
                    pos_d   = '0;
                    ready_d = 1'b0;
                    es_d    = 1'b0;
                    ed_d    = 1'b0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (code_q[pos_to_bit(pos_q[3:0])]) begin
                    syn_d = syn_q ^ pos_q[3:0];
                    par_d = ~par_q;
                end
                pos_d = pos_q + 5'd1;
                if (pos_q == 5'd15) begin
                    state_d = StCorrect;
                end
            end
            StCorrect: begin
                // Odd parity means one flipped bit, located by the syndrome
                // (syndrome 0 is the overall parity bit itself).
                if (par_q) begin
                    code_d[pos_to_bit(syn_q)] = ~code_q[pos_to_bit(syn_q)];
                end
                state_d = StExtract;
            end
            StExtract: begin
                bin_d   = payload;
                es_d    = par_q;
                ed_d    = ~par_q && (syn_q != 4'd0);
                ready_d = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers; reset aborts any decode in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            code_q  <= '0;
            syn_q   <= '0;
            par_q   <= 1'b0;
            pos_q   <= '0;
            ready_q <= 1'b0;
            bin_q   <= '0;
            es_q    <= 1'b0;
            ed_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            syn_q   <= syn_d;
            par_q   <= par_d;
            pos_q   <= pos_d;
            ready_q <= ready_d;
            bin_q   <= bin_d;
            es_q    <= es_d;
            ed_q    <= ed_d;
        end
    end

    assign ready_out  = ready_q;
    assign binary_out = bin_q;
    assign err_single = es_q;
    assign err_double = ed_q;

endmodule

// File: tb/tb_hamming_decoder_rtl.sv
// Self-checking bench for hamming_decoder_rtl: directed code words, handshake
// and reset cases, then random payloads with 0, 1 or 2 injected bit errors.
module tb_hamming_decoder_rtl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] hamm_code_in;
    logic        ready_out;
    logic [10:0] binary_out;
    logic        err_single;
    logic        err_double;

    int total = 0;
    int bad   = 0;

    // Hamming positions of payload bits, payload MSB first.
    int dpos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    hamming_decoder_rtl dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .hamm_code_in (hamm_code_in),
        .ready_out    (ready_out),
        .binary_out   (binary_out),
        .err_single   (err_single),
        .err_double   (err_double)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: place payload, then each parity bit p covers every
    // position whose index has bit p set; position 0 makes total parity even.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] v;
        logic [15:0] cw;
        v = '0;
        for (int k = 0; k < 11; k++) v[dpos[k]] = d[10-k];
        for (int p = 1; p < 16; p = p * 2) begin
            for (int n = 1; n < 16; n++) begin
                if (n != p && (n & p) != 0) v[p] = v[p] ^ v[n];
            end
        end
        v[0] = ^v[15:1];
        for (int n = 0; n < 16; n++) cw[15-n] = v[n];
        return cw;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] cw);
        logic [10:0] d;
        for (int k = 0; k < 11; k++) d[10-k] = cw[15-dpos[k]];
        return d;
    endfunction

    // Issue one request and check latency, in-flight flags and the result.
    task automatic decode_and_check(input string tag, input logic [15:0] code,
                                    input logic [10:0] exp_bin, input logic exp_s,
                                    input logic exp_d);
        int lat;
        @(negedge clock);
        hamm_code_in = code;
        start = 1'b1;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == 1) begin
                check_eq({tag, ":ready_low"}, ready_out, 0);
                check_eq({tag, ":flags_low"}, {err_single, err_double}, 0);
            end
            if (lat == 2) hamm_code_in = ~code;
        end while (!ready_out && lat < 40);
        check_eq({tag, ":latency"}, lat, 19);
        check_eq({tag, ":binary"}, binary_out, exp_bin);
        check_eq({tag, ":err_single"}, err_single, exp_s);
        check_eq({tag, ":err_double"}, err_double, exp_d);
    endtask

    // Drop start; the next request lands on the second edge after this.
    task automatic release_start();
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
    endtask

    initial begin
        logic [15:0] dir_code [7];
        logic [10:0] dir_bin  [7];
        logic        dir_s    [7];
        logic        dir_d    [7];
        int          drops;

        // Double error leaves the word unchanged, so F9FF yields its raw
        // payload 4FF; E880 corrects position 15 back to E881 -> 001.
        dir_code = '{16'h0000, 16'hFFFF, 16'hE881, 16'hFBFF, 16'h7FFF, 16'hE880, 16'hF9FF};
        dir_bin  = '{11'h000, 11'h7FF, 11'h001, 11'h7FF, 11'h7FF, 11'h001, 11'h4FF};
        dir_s    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        dir_d    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        hamm_code_in = '0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_ready", ready_out, 0);
        check_eq("reset_binary", binary_out, 0);
        check_eq("reset_flags", {err_single, err_double}, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            decode_and_check($sformatf("dir%0d", i), dir_code[i], dir_bin[i], dir_s[i], dir_d[i]);
            release_start();
        end

        // Start held high after completion must not start another decode.
        decode_and_check("hold", 16'hFFFF, 11'h7FF, 1'b0, 1'b0);
        drops = 0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (!ready_out) drops++;
        end
        check_eq("hold_no_retrigger", drops, 0);
        check_eq("hold_binary", binary_out, 11'h7FF);
        release_start();

        // Reset mid-scan clears outputs at once and leaves no partial result.
        @(negedge clock);
        hamm_code_in = 16'hE881;
        start = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        #1;
        check_eq("midreset_ready", ready_out, 0);
        check_eq("midreset_binary", binary_out, 0);
        check_eq("midreset_flags", {err_single, err_double}, 0);
        @(negedge clock);
        reset = 1'b0;
        drops = 0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (ready_out) drops++;
        end
        check_eq("midreset_no_result", drops, 0);
        decode_and_check("after_reset", 16'hE881, 11'h001, 1'b0, 1'b0);
        release_start();

        for (int i = 0; i < 40; i++) begin
            logic [10:0] pl;
            logic [15:0] cw;
            int          nerr;
            int          p1;
            int          p2;
            pl = 11'($urandom_range(0, 2047));
            nerr = $urandom_range(0, 2);
            p1 = $urandom_range(0, 15);
            p2 = (p1 + 1 + $urandom_range(0, 14)) % 16;
            cw = encode(pl);
            if (nerr >= 1) cw[15-p1] = ~cw[15-p1];
            if (nerr == 2) cw[15-p2] = ~cw[15-p2];
            if (nerr == 2)
                decode_and_check($sformatf("rnd%0d", i), cw, extract(cw), 1'b0, 1'b1);
            else
                decode_and_check($sformatf("rnd%0d", i), cw, pl, nerr == 1, 1'b0);
            release_start();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
